// File: rtl/alpha_trim_mean.sv
// alpha_trim_mean
//   Initiator/consumer for the parallel_sort rank engine in the modified
//   alpha-trimmed mean filter. Accepts one DN-pixel window, kicks the sorter,
//   captures the rank-to-index sequence, sums the pixels ranked ALPHA ..
//   DN-1-ALPHA and divides by the kept count with round-to-nearest.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   win_valid/ready  window handshake (ready only while idle)
//   win_data         DN pixels, pixel i at [i*DW +: DW]
//   sort_sig         one-cycle sort start pulse to the sorter
//   data_unsort      registered copy of the accepted window
//   sort_finish      sorter done pulse (only observed while waiting)
//   sequence_sorted  field k = original index of rank k (rank 0 smallest)
//   pix_out          filtered pixel, held until the next result
//   pix_valid        one-cycle strobe for a new pix_out
//   busy             high whenever a window is in flight
module alpha_trim_mean #(
  parameter int DN     = 25,
  parameter int DW     = 8,
  parameter int DW_SEQ = $clog2(DN),
  parameter int ALPHA  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               win_valid,
  output logic               win_ready,
  input  logic [DW*DN-1:0]   win_data,
  output logic               sort_sig,
  output logic [DW*DN-1:0]   data_unsort,
  input  logic               sort_finish,
  input  logic [DW_SEQ*DN-1:0] sequence_sorted,
  output logic [DW-1:0]      pix_out,
  output logic               pix_valid,
  output logic               busy
);

  localparam int NK = DN - 2 * ALPHA;
  localparam int SW = DW + $clog2(DN);
  localparam int CW = $clog2(SW + 1);

  localparam logic [SW-1:0]     NK_W     = SW'(NK);
  localparam logic [SW-1:0]     BIAS     = SW'(NK / 2);
  localparam logic [SW-1:0]     PIX_MAX  = SW'((1 << DW) - 1);
  localparam logic [DW_SEQ-1:0] K_FIRST  = DW_SEQ'(ALPHA);
  localparam logic [DW_SEQ-1:0] K_LAST   = DW_SEQ'(DN - 1 - ALPHA);
  localparam logic [CW-1:0]     DIV_LAST = CW'(SW - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KICK,
    ST_WAIT,
    ST_SETTLE,
    ST_ACC,
    ST_DIV,
    ST_OUT
  } state_t;

  state_t                state_reg;
  logic [DW*DN-1:0]      data_reg;
  logic [DW_SEQ*DN-1:0]  seq_reg;
  logic [SW-1:0]         acc_reg;   // running sum, then dividend/quotient shifter
  logic [SW-1:0]         rem_reg;   // division partial remainder
  logic [DW_SEQ-1:0]     k_reg;
  logic [CW-1:0]         div_cnt_reg;
  logic [DW-1:0]         pix_reg;
  logic                  pix_valid_reg;
  logic                  sort_sig_reg;
  logic                  win_ready_reg;
  logic                  busy_reg;

  // Unpacked views of the captured window and rank sequence.
  logic [DW-1:0]     pix_arr [DN];
  logic [DW_SEQ-1:0] seq_arr [DN];

  generate
    for (genvar gi = 0; gi < DN; gi++) begin : g_unpack
      assign pix_arr[gi] = data_reg[gi*DW +: DW];
      assign seq_arr[gi] = seq_reg[gi*DW_SEQ +: DW_SEQ];
    end
  endgenerate

  // Rank k -> original index -> pixel. An index >= DN matches no entry and
  // therefore contributes zero.
  logic [DW_SEQ-1:0] sel_idx;
  logic [DW-1:0]     sel_pix;

  always_comb begin
    sel_idx = '0;
    sel_pix = '0;
    for (int i = 0; i < DN; i++) begin
      if (k_reg == DW_SEQ'(i)) sel_idx = seq_arr[i];
    end
    for (int i = 0; i < DN; i++) begin
      if (sel_idx == DW_SEQ'(i)) sel_pix = pix_arr[i];
    end
  end

  // One restoring-division step: shift the next dividend bit into the
  // remainder, subtract NK when it fits, and shift the quotient bit into
  // the vacated LSB of acc_reg.
  logic [SW:0]   rem_try;
  logic          div_ge;
  logic [SW-1:0] rem_next;
  logic [SW-1:0] quot_next;
  logic [DW-1:0] pix_sat;

  always_comb begin
    rem_try   = {rem_reg, acc_reg[SW-1]};
    div_ge    = rem_try >= {1'b0, NK_W};
    rem_next  = div_ge ? SW'(rem_try - {1'b0, NK_W}) : rem_try[SW-1:0];
    quot_next = {acc_reg[SW-2:0], div_ge};
    pix_sat   = (quot_next > PIX_MAX) ? {DW{1'b1}} : quot_next[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      data_reg      <= '0;
      seq_reg       <= '0;
      acc_reg       <= '0;
      rem_reg       <= '0;
      k_reg         <= '0;
      div_cnt_reg   <= '0;
      pix_reg       <= '0;
      pix_valid_reg <= 1'b0;
      sort_sig_reg  <= 1'b0;
      win_ready_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      sort_sig_reg  <= 1'b0;
      pix_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          win_ready_reg <= 1'b1;
          if (win_valid && win_ready_reg) begin
            data_reg      <= win_data;
            sort_sig_reg  <= 1'b1;
            win_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= ST_KICK;
          end
        end
        ST_KICK: begin
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sort_finish) state_reg <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // The sequence is valid only from the cycle after sort_finish.
          seq_reg   <= sequence_sorted;
          acc_reg   <= BIAS;
          k_reg     <= K_FIRST;
          state_reg <= ST_ACC;
        end
        ST_ACC: begin
          acc_reg <= acc_reg + SW'(sel_pix);
          if (k_reg == K_LAST) begin
            rem_reg     <= '0;
            div_cnt_reg <= '0;
            state_reg   <= ST_DIV;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        ST_DIV: begin
          acc_reg     <= quot_next;
          rem_reg     <= rem_next;
          div_cnt_reg <= div_cnt_reg + 1'b1;
          if (div_cnt_reg == DIV_LAST) begin
            pix_reg       <= pix_sat;
            pix_valid_reg <= 1'b1;
            state_reg     <= ST_OUT;
          end
        end
        ST_OUT: begin
          win_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign win_ready   = win_ready_reg;
  assign sort_sig    = sort_sig_reg;
  assign data_unsort = data_reg;
  assign pix_out     = pix_reg;
  assign pix_valid   = pix_valid_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_alpha_trim_mean.sv
// Testbench for alpha_trim_mean with a behavioural parallel_sort stand-in.
module tb_alpha_trim_mean;

  localparam int DN     = 25;
  localparam int DW     = 8;
  localparam int DW_SEQ = $clog2(DN);
  localparam int ALPHA  = 6;
  localparam int NK     = DN - 2 * ALPHA;

  logic                 clk;
  logic                 rst_n;
  logic                 win_valid;
  logic                 win_ready;
  logic [DW*DN-1:0]     win_data;
  logic                 sort_sig;
  logic [DW*DN-1:0]     data_unsort;
  logic                 sort_finish;
  logic [DW_SEQ*DN-1:0] sequence_sorted;
  logic [DW-1:0]        pix_out;
  logic                 pix_valid;
  logic                 busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int seq_tb [DN];   // rank -> index list the sorter will deliver
  bit spur_en = 1'b0;

  alpha_trim_mean #(.DN(DN), .DW(DW), .DW_SEQ(DW_SEQ), .ALPHA(ALPHA)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .win_valid       (win_valid),
    .win_ready       (win_ready),
    .win_data        (win_data),
    .sort_sig        (sort_sig),
    .data_unsort     (data_unsort),
    .sort_finish     (sort_finish),
    .sequence_sorted (sequence_sorted),
    .pix_out         (pix_out),
    .pix_valid       (pix_valid),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic garbage_seq();
    for (int k = 0; k < DN; k++) sequence_sorted[k*DW_SEQ +: DW_SEQ] = DW_SEQ'($urandom);
  endtask

  // Behavioural sorter: sort_finish 3 cycles after sort_sig, sequence valid
  // the following cycle, garbage afterwards. Optionally a spurious finish
  // pulse lands at F+5 (mid-accumulation).
  initial begin
    sort_finish = 1'b0;
    garbage_seq();
    forever begin
      @(negedge clk);
      if (sort_sig) begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sort_finish = 1'b1;
        @(posedge clk); #1;
        sort_finish = 1'b0;
        for (int k = 0; k < DN; k++) sequence_sorted[k*DW_SEQ +: DW_SEQ] = DW_SEQ'(seq_tb[k]);
        @(posedge clk); #1;
        garbage_seq();
        if (spur_en) begin
          @(posedge clk); #1;
          @(posedge clk); #1;
          @(posedge clk); #1;
          sort_finish = 1'b1;
          @(posedge clk); #1;
          sort_finish = 1'b0;
        end
      end
    end
  end

  function automatic int pix_of(input logic [DW*DN-1:0] w, input int i);
    return int'(w[i*DW +: DW]);
  endfunction

  // Reference: sort the pixel values, keep the middle NK, round to nearest.
  function automatic int ref_sorted(input logic [DW*DN-1:0] w);
    int q[$];
    int s;
    for (int i = 0; i < DN; i++) q.push_back(pix_of(w, i));
    q.sort();
    s = 0;
    for (int k = ALPHA; k <= DN - 1 - ALPHA; k++) s += q[k];
    return (s + NK / 2) / NK;
  endfunction

  // Reference for an arbitrary delivered sequence (out-of-range index = 0).
  function automatic int ref_seq(input logic [DW*DN-1:0] w);
    int s;
    s = 0;
    for (int k = ALPHA; k <= DN - 1 - ALPHA; k++)
      if (seq_tb[k] < DN) s += pix_of(w, seq_tb[k]);
    return (s + NK / 2) / NK;
  endfunction

  task automatic seq_identity();
    for (int i = 0; i < DN; i++) seq_tb[i] = i;
  endtask

  // Stable ascending index sort of the window values.
  task automatic sort_into_tb(input logic [DW*DN-1:0] w);
    int t;
    seq_identity();
    for (int i = 1; i < DN; i++)
      for (int j = i; j > 0; j--)
        if (pix_of(w, seq_tb[j-1]) > pix_of(w, seq_tb[j])) begin
          t = seq_tb[j]; seq_tb[j] = seq_tb[j-1]; seq_tb[j-1] = t;
        end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!win_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 256'(win_ready), 256'(1));
  endtask

  task automatic run_window(input logic [DW*DN-1:0] w, input int exp, input string tag);
    int a, lat, ss_cnt, ss_at;
    bit stable;
    logic [DW-1:0] got;
    lat = -1; ss_cnt = 0; ss_at = -1; stable = 1'b1; got = '0;
    wait_ready(tag);
    win_valid = 1'b1;
    win_data  = w;
    a = cyc;
    @(posedge clk); #1;
    win_valid = 1'b0;
    for (int i = 0; i < DN; i++) win_data[i*DW +: DW] = DW'($urandom);
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (busy && data_unsort !== w) stable = 1'b0;
      if (sort_sig) begin ss_cnt++; ss_at = cyc - a; end
      if (pix_valid) begin lat = cyc - a; got = pix_out; break; end
    end
    $display("window %s pix_out=%0d expected=%0d latency=%0d", tag, got, exp, lat);
    chk({tag, "_pix"},      256'(got),    256'(exp));
    chk({tag, "_latency"},  256'(lat),    256'(32));
    chk({tag, "_kick_cnt"}, 256'(ss_cnt), 256'(1));
    chk({tag, "_kick_at"},  256'(ss_at),  256'(1));
    chk({tag, "_stable"},   256'(stable), 256'(1));
    @(negedge clk);
    chk({tag, "_pv_drop"},  256'(pix_valid), 256'(0));
    chk({tag, "_hold"},     256'(pix_out),   256'(exp));
    chk({tag, "_rdy_back"}, 256'(win_ready), 256'(1));
  endtask

  initial begin
    logic [DW*DN-1:0] w, w2;
    int a, a2, p1, lat2, pv, e1, e2;
    bit stable;

    rst_n = 1'b0; win_valid = 1'b0; win_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 256'(win_ready),   256'(0));
    chk("rst_kick",  256'(sort_sig),    256'(0));
    chk("rst_data",  256'(data_unsort), 256'(0));
    chk("rst_pix",   256'(pix_out),     256'(0));
    chk("rst_pv",    256'(pix_valid),   256'(0));
    chk("rst_busy",  256'(busy),        256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_ready", 256'(win_ready), 256'(1));
    chk("rel_busy",  256'(busy),      256'(0));

    // Flat window
    for (int i = 0; i < DN; i++) w[i*DW +: DW] = 8'd100;
    seq_identity();
    run_window(w, 100, "flat");

    // Ramp, identity sequence
    for (int i = 0; i < DN; i++) w[i*DW +: DW] = DW'(10 * i);
    seq_identity();
    run_window(w, 120, "ramp");

    // Impulses
    for (int i = 0; i < DN; i++) w[i*DW +: DW] = 8'd50;
    w[3*DW +: DW]  = 8'd0;
    w[17*DW +: DW] = 8'd255;
    sort_into_tb(w);
    run_window(w, 50, "impulse");

    // Rounding: ranks laid out in index order
    for (int i = 0; i < DN; i++)
      w[i*DW +: DW] = (i < 6) ? 8'd0 : (i < 18) ? 8'd10 : (i == 18) ? 8'd17 : 8'd255;
    seq_identity();
    run_window(w, 11, "round");

    // Out-of-range index in a kept rank contributes zero
    for (int i = 0; i < DN; i++) w[i*DW +: DW] = 8'd100;
    seq_identity();
    seq_tb[10] = 31;
    run_window(w, ref_seq(w), "badidx");

    // Random windows against the sorted-value reference
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DN; i++) w[i*DW +: DW] = DW'($urandom);
      sort_into_tb(w);
      run_window(w, ref_sorted(w), $sformatf("rand%0d", r));
    end

    // Handshake: win_valid held high across two windows, spurious finish in ACC
    for (int i = 0; i < DN; i++) begin
      w[i*DW +: DW]  = DW'($urandom);
      w2[i*DW +: DW] = DW'($urandom);
    end
    e1 = ref_sorted(w);
    e2 = ref_sorted(w2);
    sort_into_tb(w);
    spur_en = 1'b1;
    wait_ready("hs1");
    win_valid = 1'b1;
    win_data  = w;
    a = cyc; p1 = -1; a2 = -1; stable = 1'b1;
    @(posedge clk); #1;
    win_data = w2;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (p1 < 0) begin
        if (busy && data_unsort !== w) stable = 1'b0;
        if (pix_valid) begin
          p1 = cyc;
          $display("window hs1 pix_out=%0d expected=%0d latency=%0d", pix_out, e1, p1 - a);
          chk("hs1_pix", 256'(pix_out), 256'(e1));
          sort_into_tb(w2);
        end
      end else if (win_ready && win_valid) begin
        a2 = cyc;
        break;
      end
    end
    spur_en = 1'b0;
    chk("hs1_latency", 256'(p1 - a), 256'(32));
    chk("hs1_stable",  256'(stable), 256'(1));
    chk("hs2_accept",  256'(a2),     256'(p1 + 1));
    @(posedge clk); #1;
    win_valid = 1'b0;
    lat2 = -1;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (pix_valid) begin lat2 = cyc - a2; break; end
    end
    $display("window hs2 pix_out=%0d expected=%0d latency=%0d", pix_out, e2, lat2);
    chk("hs2_pix",     256'(pix_out),     256'(e2));
    chk("hs2_latency", 256'(lat2),        256'(32));
    chk("hs2_data",    256'(data_unsort), 256'(w2));

    // Reset in the middle of accumulation (F+5)
    for (int i = 0; i < DN; i++) w[i*DW +: DW] = 8'd100;
    seq_identity();
    wait_ready("rstmid");
    win_valid = 1'b1;
    win_data  = w;
    a = cyc;
    @(posedge clk); #1;
    win_valid = 1'b0;
    while (cyc < a + 9) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_ready", 256'(win_ready),   256'(0));
    chk("mid_kick",  256'(sort_sig),    256'(0));
    chk("mid_data",  256'(data_unsort), 256'(0));
    chk("mid_pix",   256'(pix_out),     256'(0));
    chk("mid_pv",    256'(pix_valid),   256'(0));
    chk("mid_busy",  256'(busy),        256'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rel_ready", 256'(win_ready), 256'(1));
    pv = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (pix_valid) pv++;
    end
    $display("window rstmid aborted pix_valid_count=%0d", pv);
    chk("mid_no_pv", 256'(pv), 256'(0));
    for (int i = 0; i < DN; i++) w[i*DW +: DW] = 8'd200;
    seq_identity();
    run_window(w, 200, "flat200");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
